mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: memory-port owner encoding and
// default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        VGA,
        CPU
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (VGA scanout, CPU) in front of a synchronous single-port
// SRAM. VGA has fixed priority, bounded by a CPU starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    owner_t           owner;
    owner_t           rd_tag;
    owner_t           next_owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             armed;
    logic             cpu_first;

    // The first edge after reset release only arms the arbiter, so no grant
    // can appear in the first cycle out of reset.
    always_comb begin
        cpu_first  = (STARVE_MAX != 0) && (starve_cnt == CNT_MAX);
        next_owner = IDLE;
        if (armed) begin
            if (vga_req && !(cpu_req && cpu_first)) begin
                next_owner = VGA;
            end else if (cpu_req) begin
                next_owner = CPU;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            armed      <= 1'b0;
            owner      <= IDLE;
            rd_tag     <= IDLE;
            starve_cnt <= '0;
            vga_gnt    <= 1'b0;
            cpu_gnt    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            armed   <= 1'b1;
            owner   <= next_owner;
            vga_gnt <= (next_owner == VGA);
            cpu_gnt <= (next_owner == CPU);
            mem_en  <= (next_owner != IDLE);
            mem_we  <= (next_owner == CPU) && cpu_we;
            case (next_owner)
                VGA: begin
                    mem_addr  <= vga_addr;
                    mem_wdata <= '0;
                end
                CPU: begin
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_we ? cpu_wdata : '0;
                end
                default: begin
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase

            // Tag the access now on the port so its read data is routed back
            // to the right requester one cycle later; writes return nothing.
            if (owner == VGA) begin
                rd_tag <= VGA;
            end else if (owner == CPU && !mem_we) begin
                rd_tag <= CPU;
            end else begin
                rd_tag <= IDLE;
            end

            if (!cpu_req || next_owner == CPU) begin
                starve_cnt <= '0;
            end else if (next_owner == VGA && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign vga_rvalid = (rd_tag == VGA);
    assign cpu_rvalid = (rd_tag == CPU);
    assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a behavioural SRAM and a
// bench-side reference memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_async;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [7:0]  vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        z_vga_gnt;
    logic        z_vga_rvalid;
    logic [7:0]  z_vga_rdata;
    logic        z_cpu_gnt;
    logic        z_cpu_rvalid;
    logic [7:0]  z_cpu_rdata;
    logic        z_mem_en;
    logic        z_mem_we;
    logic [15:0] z_mem_addr;
    logic [7:0]  z_mem_wdata;
    logic [7:0]  z_mem_rdata;

    int tests_run;
    int tests_failed;

    logic [7:0] sram    [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_async(rst_async),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(0)) dut_z (
        .clk(clk), .rst_async(rst_async),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(z_vga_gnt),
        .vga_rvalid(z_vga_rvalid), .vga_rdata(z_vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(z_cpu_gnt),
        .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    assign z_mem_rdata = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed address pattern (0x0100 -> 0x5A).
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5B;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] = mem_wdata;
            else        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : pat(mem_addr);
        end
    end

    task automatic test_reset;
        rst_async = 1'b1;
        vga_req = 1'b1; vga_addr = 16'h1234;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5678; cpu_wdata = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({vga_gnt, cpu_gnt} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt: got %b expected 00", {vga_gnt, cpu_gnt});
        end
        tests_run++;
        if ({mem_en, mem_we} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_ctrl: got %b expected 00", {mem_en, mem_we});
        end
        tests_run++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_bus: got %h expected 000000", {mem_addr, mem_wdata});
        end
        tests_run++;
        if ({vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata} !== 18'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_read_side: got %h expected 0",
                     {vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata});
        end
        tests_run++;
        if ({z_vga_gnt, z_cpu_gnt, z_mem_en} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut_z: got %b expected 000", {z_vga_gnt, z_cpu_gnt, z_mem_en});
        end
        vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1 rst_async = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_vga_read;
        @(posedge clk); #1 vga_req = 1'b1; vga_addr = 16'h0100;
        @(posedge clk); #1 vga_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({vga_gnt, cpu_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 16'h0100) begin
            tests_failed++;
            $display("[TB] FAIL vga_grant: got gnt/cpu/en/we=%b addr=%h expected 1010 addr=0100",
                     {vga_gnt, cpu_gnt, mem_en, mem_we}, mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (vga_rvalid !== 1'b1 || vga_rdata !== 8'h5A || vga_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL vga_rvalid: got rvalid=%b data=%h gnt=%b cpu_gnt=%b expected 1 5a 0 0",
                     vga_rvalid, vga_rdata, vga_gnt, cpu_gnt);
        end
        @(negedge clk);
        tests_run++;
        if (vga_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL vga_idle_after: got rvalid=%b en=%b expected 0 0", vga_rvalid, mem_en);
        end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hC3;
        ref_mem[16'h2000] = 8'hC3;
        @(posedge clk); #1 cpu_we = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cpu_gnt, vga_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 16'h2000 || mem_wdata !== 8'hC3) begin
            tests_failed++;
            $display("[TB] FAIL cpu_write_grant: got gnt/vga/en/we=%b addr=%h wdata=%h expected 1011 2000 c3",
                     {cpu_gnt, vga_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cpu_gnt, mem_en, mem_we, cpu_rvalid} !== 4'b1100 || mem_addr !== 16'h2000) begin
            tests_failed++;
            $display("[TB] FAIL cpu_read_grant: got gnt/en/we/rvalid=%b addr=%h expected 1100 2000",
                     {cpu_gnt, mem_en, mem_we, cpu_rvalid}, mem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hC3 || cpu_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cpu_rvalid: got rvalid=%b data=%h gnt=%b expected 1 c3 0",
                     cpu_rvalid, cpu_rdata, cpu_gnt);
        end
        @(negedge clk);
        tests_run++;
        if (cpu_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cpu_rvalid_once: got %b expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_starvation;
        logic exp_cpu;
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = 16'h0300;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h11;
        ref_mem[16'h3000] = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp_cpu = ((i % 5) == 4);
            tests_run++;
            if (cpu_gnt !== exp_cpu || vga_gnt !== !exp_cpu) begin
                tests_failed++;
                $display("[TB] FAIL starve_pattern[%0d]: got vga=%b cpu=%b expected vga=%b cpu=%b",
                         i, vga_gnt, cpu_gnt, !exp_cpu, exp_cpu);
            end
        end
        @(posedge clk); #1 vga_req = 1'b0; cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_starve_disabled;
        @(posedge clk); #1;
        vga_req = 1'b1; vga_addr = 16'h0300;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if (z_cpu_gnt !== 1'b0 || z_vga_gnt !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL starve0[%0d]: got vga=%b cpu=%b expected vga=1 cpu=0",
                         i, z_vga_gnt, z_cpu_gnt);
            end
        end
        @(posedge clk); #1 vga_req = 1'b0; cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_read;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midread_grant: got %b expected 1", cpu_gnt);
        end
        @(posedge clk); #1 rst_async = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({cpu_rvalid, cpu_gnt, vga_gnt, mem_en, mem_we} !== 5'b0 || cpu_rdata !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL midread_in_reset: got %b data=%h expected 00000 00",
                     {cpu_rvalid, cpu_gnt, vga_gnt, mem_en, mem_we}, cpu_rdata);
        end
        @(posedge clk); #1 rst_async = 1'b0; vga_req = 1'b1; vga_addr = 16'h0777;
        @(negedge clk);
        tests_run++;
        if ({cpu_rvalid, vga_rvalid, cpu_gnt, vga_gnt, mem_en} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_cycle0: got %b expected 00000",
                     {cpu_rvalid, vga_rvalid, cpu_gnt, vga_gnt, mem_en});
        end
        @(negedge clk);
        tests_run++;
        if ({cpu_rvalid, vga_rvalid, cpu_gnt, vga_gnt, mem_en} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_first_edge: got %b expected 00000",
                     {cpu_rvalid, vga_rvalid, cpu_gnt, vga_gnt, mem_en});
        end
        @(posedge clk); #1 vga_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (vga_gnt !== 1'b1 || mem_addr !== 16'h0777) begin
            tests_failed++;
            $display("[TB] FAIL release_first_grant: got gnt=%b addr=%h expected 1 0777", vga_gnt, mem_addr);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic       exp_vrv, exp_crv;
        logic [7:0] exp_vd, exp_cd;
        int         vwait, cwait;
        exp_vrv = 1'b0; exp_crv = 1'b0; exp_vd = '0; exp_cd = '0;
        vwait = 0; cwait = 0;
        vga_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 420; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (vga_gnt && cpu_gnt) begin
                tests_failed++;
                $display("[TB] FAIL rand_one_hot[%0d]: got both grants expected at most one", i);
            end
            tests_run++;
            if (vga_rvalid !== exp_vrv || (exp_vrv && vga_rdata !== exp_vd)) begin
                tests_failed++;
                $display("[TB] FAIL rand_vga_rd[%0d]: got %b/%h expected %b/%h",
                         i, vga_rvalid, vga_rdata, exp_vrv, exp_vd);
            end
            tests_run++;
            if (cpu_rvalid !== exp_crv || (exp_crv && cpu_rdata !== exp_cd)) begin
                tests_failed++;
                $display("[TB] FAIL rand_cpu_rd[%0d]: got %b/%h expected %b/%h",
                         i, cpu_rvalid, cpu_rdata, exp_crv, exp_cd);
            end
            exp_vrv = 1'b0; exp_crv = 1'b0;
            if (vga_gnt) begin
                tests_run++;
                if (!vga_req || mem_addr !== vga_addr || mem_we !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_vga_gnt[%0d]: got req=%b addr=%h we=%b expected 1 %h 0",
                             i, vga_req, mem_addr, mem_we, vga_addr);
                end
                exp_vrv = 1'b1; exp_vd = ref_read(vga_addr);
            end
            if (cpu_gnt) begin
                tests_run++;
                if (!cpu_req || mem_addr !== cpu_addr || mem_we !== cpu_we ||
                    (cpu_we && mem_wdata !== cpu_wdata)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_cpu_gnt[%0d]: got req=%b addr=%h we=%b wd=%h expected 1 %h %b %h",
                             i, cpu_req, mem_addr, mem_we, mem_wdata, cpu_addr, cpu_we, cpu_wdata);
                end
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin
                    exp_crv = 1'b1; exp_cd = ref_read(cpu_addr);
                end
            end
            vwait = (vga_req && !vga_gnt) ? vwait + 1 : 0;
            cwait = (cpu_req && !cpu_gnt) ? cwait + 1 : 0;
            tests_run++;
            if (vwait > 8 || cwait > 8) begin
                tests_failed++;
                $display("[TB] FAIL rand_wait[%0d]: got vga=%0d cpu=%0d cycles expected <= 8", i, vwait, cwait);
                vwait = 0; cwait = 0;
            end
            if (vga_gnt || !vga_req) begin
                vga_req  = (i < 400) && ($urandom_range(0, 3) != 0);
                vga_addr = 16'h4000 | 16'($urandom_range(0, 15));
            end
            if (cpu_gnt || !cpu_req) begin
                cpu_req   = (i < 400) && ($urandom_range(0, 1) != 0);
                cpu_we    = ($urandom_range(0, 1) != 0);
                cpu_addr  = 16'h4000 | 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_async = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_vga_read();
        test_back_to_back();
        test_starvation();
        test_starve_disabled();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
